fetch_instr_queue: RTL and testbench

//  Decoupling FIFO between the fetch stage and decode. Captures each valid
//  {instruction, PC, PC+4} triple from fetch and presents it in order to decode.

---
 rtl/fetch_instr_queue.sv | 136 +++++++++++++
 tb/tb_fetch_instr_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_instr_queue.sv
// ---------------------------------------------------------------------------
// fetch_instr_queue
//   Decoupling FIFO between fetch and decode. Each valid fetch triple
//   {instruction, PC, PC+4} is captured and presented to decode in order.
//   Full_OUT back-pressures fetch (STALL); FLUSH discards every entry on a
//   commit-side redirect so no wrong-path instruction reaches decode.
//
// Ports
//   CLK           in   1        clock, all state updates on posedge
//   RESET         in   1        synchronous active-low reset
//   FLUSH         in   1        commit redirect, discard all entries
//   In_Valid      in   1        fetch presents a valid instruction
//   In_Instr      in   32       fetched instruction word
//   In_PC         in   32       address of fetched instruction
//   In_PC_Plus4   in   32       address of following instruction
//   Full_OUT      out  1        queue full, drives fetch STALL
//   Out_Valid     out  1        head entry valid for decode
//   Out_Instr     out  32       head instruction
//   Out_PC        out  32       head PC
//   Out_PC_Plus4  out  32       head PC+4
//   Out_Ready     in   1        decode accepts head this cycle
//   Count_OUT     out  PTR_W+1  occupancy, 0..DEPTH
//
// Build option
//   IFQ_BYPASS_EN  when defined, an instruction arriving at an empty queue is
//                  passed straight through to decode in the same cycle.
// ---------------------------------------------------------------------------
module fetch_instr_queue #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             FLUSH,
   input  logic             In_Valid,
   input  logic [31:0]      In_Instr,
   input  logic [31:0]      In_PC,
   input  logic [31:0]      In_PC_Plus4,
   output logic             Full_OUT,
   output logic             Out_Valid,
   output logic [31:0]      Out_Instr,
   output logic [31:0]      Out_PC,
   output logic [31:0]      Out_PC_Plus4,
   input  logic             Out_Ready,
   output logic [PTR_W:0]   Count_OUT
);

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [95:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   logic empty;
   logic push;
   logic pop;
   logic wr_en;
   logic bypass;

   assign empty     = (count_q == '0);
   assign Full_OUT  = (count_q == CNT_FULL);
   assign Count_OUT = count_q;

   // Full is taken from the registered count only, so a pop in the same
   // cycle never frees a slot for the incoming instruction.
   assign push = In_Valid && !Full_OUT;
   assign pop  = !empty && Out_Ready;

`ifdef IFQ_BYPASS_EN
   assign bypass = empty && In_Valid && !FLUSH && RESET;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed instruction that decode takes immediately is never stored.
   assign wr_en = push && !FLUSH && !(bypass && Out_Ready);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (FLUSH) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (wr_en) tail_d = tail_q + PTR_ONE;
         if (pop)   head_d = head_q + PTR_ONE;
         unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is never cleared; entries become unreachable once count is 0.
   always_ff @(posedge CLK) begin
      if (RESET && wr_en) begin
         mem_q[tail_q] <= {In_Instr, In_PC, In_PC_Plus4};
      end
   end

   // Head data is forced to zero while empty so stale or uninitialised
   // storage never reaches decode.
   always_comb begin
      Out_Valid    = !empty;
      Out_Instr    = '0;
      Out_PC       = '0;
      Out_PC_Plus4 = '0;
      if (bypass) begin
         Out_Valid    = 1'b1;
         Out_Instr    = In_Instr;
         Out_PC       = In_PC;
         Out_PC_Plus4 = In_PC_Plus4;
      end else if (!empty) begin
         {Out_Instr, Out_PC, Out_PC_Plus4} = mem_q[head_q];
      end
   end

endmodule

// File: tb/tb_fetch_instr_queue.sv
module tb_fetch_instr_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr, in_pc, in_pc4;
   logic        full;
   logic        out_valid;
   logic [31:0] out_instr, out_pc, out_pc4;
   logic        out_ready;
   logic [3:0]  count;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   fetch_instr_queue #(.DEPTH(8), .PTR_W(3)) dut (
      .CLK(clk), .RESET(rst_n), .FLUSH(flush),
      .In_Valid(in_valid), .In_Instr(in_instr), .In_PC(in_pc), .In_PC_Plus4(in_pc4),
      .Full_OUT(full), .Out_Valid(out_valid), .Out_Instr(out_instr),
      .Out_PC(out_pc), .Out_PC_Plus4(out_pc4), .Out_Ready(out_ready),
      .Count_OUT(count)
   );

   // Reference model: an ordered list of {instr, pc, pc4} entries.
   logic [95:0] mq[$];
   logic        m_valid, m_full;
   int          m_count;
   logic [31:0] m_instr, m_pc, m_pc4;

   function automatic void model_comb();
      m_count = mq.size();
      m_full  = (mq.size() == 8);
      m_valid = (mq.size() != 0);
      {m_instr, m_pc, m_pc4} = 96'h0;
      if (m_valid) {m_instr, m_pc, m_pc4} = mq[0];
`ifdef IFQ_BYPASS_EN
      if (mq.size() == 0 && in_valid && !flush && rst_n) begin
         m_valid = 1'b1;
         m_instr = in_instr; m_pc = in_pc; m_pc4 = in_pc4;
      end
`endif
   endfunction

   task automatic tick();
      bit          clr, do_pop, do_push;
      logic [95:0] e;
      clr     = !rst_n || flush;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() < 8);
`ifdef IFQ_BYPASS_EN
      if (mq.size() == 0 && out_ready) do_push = 1'b0;
`endif
      e = {in_instr, in_pc, in_pc4};
      @(posedge clk);
      if (clr) mq.delete();
      else begin
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
      in_valid  = v;
      in_pc     = pc;
      in_pc4    = pc + 32'd4;
      in_instr  = $urandom;
      out_ready = rdy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0;
      drive(1'b1, 32'hBFC00000, 1'b0);
      tick(); tick();
      #1;
      checks++; if (count !== 4'd0)      begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++; if (full !== 1'b0)       begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
      checks++; if (out_pc !== 32'h0)    begin fails++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'hBFC00000 + 32'(4*i), 1'b0);
         tick();
      end
      #1;
      checks++; if (full !== 1'b1)   begin fails++; $display("FAIL fill_full: got %b expected 1", full); end
      checks++; if (count !== 4'd8)  begin fails++; $display("FAIL fill_count: got %0d expected 8", count); end
      drive(1'b1, 32'hBFC00020, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (count !== 4'd8)          begin fails++; $display("FAIL fill_drop_count: got %0d expected 8", count); end
      checks++; if (out_pc !== 32'hBFC00000) begin fails++; $display("FAIL fill_head: got %h expected bfc00000", out_pc); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         #1;
         checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, out_valid); end
         checks++; if (out_pc !== 32'hBFC00000 + 32'(4*i))
            begin fails++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, out_pc, 32'hBFC00000 + 32'(4*i)); end
         checks++; if (out_pc4 !== 32'hBFC00004 + 32'(4*i))
            begin fails++; $display("FAIL drain_pc4[%0d]: got %h expected %h", i, out_pc4, 32'hBFC00004 + 32'(4*i)); end
         tick();
      end
      out_ready = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_concurrent();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h00001000 + 32'(4*i), 1'b0);
         tick();
      end
      for (int i = 3; i < 13; i++) begin
         drive(1'b1, 32'h00001000 + 32'(4*i), 1'b1);
         #1;
         model_comb();
         checks++; if (count !== 4'd3)   begin fails++; $display("FAIL conc_count[%0d]: got %0d expected 3", i, count); end
         checks++; if (out_pc !== 32'h00001000 + 32'(4*(i-3)))
            begin fails++; $display("FAIL conc_pc[%0d]: got %h expected %h", i, out_pc, 32'h00001000 + 32'(4*(i-3))); end
         checks++; if (out_instr !== m_instr) begin fails++; $display("FAIL conc_instr[%0d]: got %h expected %h", i, out_instr, m_instr); end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b1);
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h00002000 + 32'(4*i), 1'b0);
         tick();
      end
      #1;
      checks++; if (count !== 4'd5) begin fails++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
      flush = 1'b1;
      drive(1'b1, 32'h80000000, 1'b0);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (count !== 4'd0)     begin fails++; $display("FAIL flush_count: got %0d expected 0", count); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
      drive(1'b1, 32'h80000004, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (count !== 4'd1)          begin fails++; $display("FAIL flush_push_count: got %0d expected 1", count); end
      checks++; if (out_pc !== 32'h80000004) begin fails++; $display("FAIL flush_push_pc: got %h expected 80000004", out_pc); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_bypass();
      drive(1'b1, 32'hBFC00040, 1'b1);
      #1;
`ifdef IFQ_BYPASS_EN
      checks++; if (out_valid !== 1'b1)      begin fails++; $display("FAIL byp_valid: got %b expected 1", out_valid); end
      checks++; if (out_pc !== 32'hBFC00040) begin fails++; $display("FAIL byp_pc: got %h expected bfc00040", out_pc); end
      tick();
      drive(1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (count !== 4'd0) begin fails++; $display("FAIL byp_count: got %0d expected 0", count); end
`else
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL byp_valid: got %b expected 0", out_valid); end
      tick();
      drive(1'b0, 32'h0, 1'b0);
      #1;
      checks++; if (out_valid !== 1'b1)      begin fails++; $display("FAIL byp_late_valid: got %b expected 1", out_valid); end
      checks++; if (out_pc !== 32'hBFC00040) begin fails++; $display("FAIL byp_late_pc: got %h expected bfc00040", out_pc); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
`endif
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h00003000 + 32'(4*i), 1'b0);
         tick();
      end
      rst_n = 1'b0;
      drive(1'b1, 32'h00003100, 1'b1);
      tick();
      #1;
      checks++; if (count !== 4'd0)       begin fails++; $display("FAIL midrst_count: got %0d expected 0", count); end
      checks++; if (out_valid !== 1'b0)   begin fails++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
      checks++; if (out_instr !== 32'h0)  begin fails++; $display("FAIL midrst_instr: got %h expected 0", out_instr); end
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         flush = ($urandom_range(0, 19) == 0);
         drive(($urandom_range(0, 9) < 6), $urandom & 32'hFFFFFFFC, $urandom_range(0, 1) == 1);
         #1;
         model_comb();
         checks++; if (count !== 4'(m_count)) begin fails++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, count, m_count); end
         checks++; if (out_valid !== m_valid) begin fails++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, out_valid, m_valid); end
         checks++; if (full !== m_full)       begin fails++; $display("FAIL rnd_full[%0d]: got %b expected %b", c, full, m_full); end
         if (m_valid) begin
            checks++; if ({out_instr, out_pc, out_pc4} !== {m_instr, m_pc, m_pc4})
               begin fails++; $display("FAIL rnd_data[%0d]: got %h/%h/%h expected %h/%h/%h", c, out_instr, out_pc, out_pc4, m_instr, m_pc, m_pc4); end
         end
         tick();
      end
      rst_n = 1'b1; flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      @(negedge clk);
      test_reset();
      test_fill();
      test_drain();
      test_concurrent();
      test_flush();
      test_bypass();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
